fpga_efuse_cfg_loader: RTL

//  Boot-time configuration sequencer for the FPGA fabric.
//  - Acts as Wishbone master to efuse_ctrl and reads CFG_BYTES bytes starting at START_ADDR.
//  - Serialises each byte, LSB first, into the fabric config shift chain (cfg_data_o / cfg_en_o).
//  - Reports busy, done and error (ack timeout) status to the power-on / reset logic.

---
 rtl/fpga_efuse_cfg_loader.sv | 98 +++++++++
 1 files changed

// File: rtl/fpga_efuse_cfg_loader.sv
// fpga_efuse_cfg_loader: reads efuse bytes over Wishbone at boot and
// shifts each one LSB first into the fabric configuration chain.
module fpga_efuse_cfg_loader #(
  parameter int CFG_BYTES  = 256,
  parameter int START_ADDR = 0,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic        wb_sel_o,
  output logic [10:0] wb_adr_o,
  input  logic        wb_ack_i,
  input  logic [7:0]  wb_dat_i,
  output logic        cfg_data_o,
  output logic        cfg_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(CFG_BYTES + 1);

  if (START_ADDR + CFG_BYTES > 2048 || CFG_BYTES < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_chk
    $error("fpga_efuse_cfg_loader: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, REQ, SHIFT, DONE, ERR} state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_tmo;
  logic [BW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic [10:0]   r_adr;
  logic          w_last_bit, w_last_byte, w_tmo, w_start;

  assign w_last_bit  = r_bit == 3'd7;
  assign w_last_byte = r_cnt == BW'(CFG_BYTES - 1);
  assign w_tmo       = r_tmo == TW'(TIMEOUT - 1);
  assign w_start     = start_i && (r_state == IDLE || r_state == DONE || r_state == ERR);

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) r_state <= IDLE;
    else r_state <= w_next;

  // ack is tested before the timeout so an ack on the final cycle still succeeds
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: w_next = start_i ? REQ : r_state;
      REQ:             w_next = wb_ack_i ? SHIFT : w_tmo ? ERR : REQ;
      SHIFT:           w_next = !w_last_bit ? SHIFT : w_last_byte ? DONE : REQ;
      default:         w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_tmo <= '0;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh  <= '0;
      r_adr <= 11'(START_ADDR);
    end else if (w_start) begin
      r_tmo <= '0;
      r_cnt <= '0;
      r_bit <= '0;
      r_adr <= 11'(START_ADDR);
    end else if (r_state == REQ) begin
      r_tmo <= r_tmo + 1'b1;
      if (wb_ack_i) begin
        r_sh  <= wb_dat_i;
        r_bit <= '0;
      end
    end else if (r_state == SHIFT) begin
      r_sh  <= r_sh >> 1;
      r_bit <= r_bit + 1'b1;
      if (w_last_bit && !w_last_byte) begin
        r_cnt <= r_cnt + 1'b1;
        r_adr <= r_adr + 1'b1;
        r_tmo <= '0;
      end
    end

  assign wb_cyc_o   = r_state == REQ;
  assign wb_stb_o   = wb_cyc_o;
  assign wb_sel_o   = wb_cyc_o;
  assign wb_we_o    = 1'b0;
  assign wb_adr_o   = r_adr;
  assign cfg_en_o   = r_state == SHIFT;
  assign cfg_data_o = cfg_en_o & r_sh[0];
  assign busy_o     = r_state == REQ || r_state == SHIFT;
  assign done_o     = r_state == DONE;
  assign err_o      = r_state == ERR;
endmodule
